qspi_cmd_gen: RTL and testbench

- Control-level command generator sitting directly upstream of the QSPI transfer level; drives its io_buf_req_* request interface.
- Accepts one high-level flash operation (read, quad read, page program, sector erase) with word address and length.
- Splits the operation into flash requests that respect a max burst and 256-byte page boundaries, issuing one at a time.
- Tracks each request's completion through the instruction-label echo.

---
 rtl/qspi_cmd_gen.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_qspi_cmd_gen.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_cmd_gen.sv
// qspi_cmd_gen: control-level command generator feeding the QSPI transfer level.
//
// Takes one flash operation (read, quad read, page program, sector erase) with a
// word address and word count. It splits the operation into transfer-level requests
// bounded by MAX_BURST and, for page program, by PAGE_WORDS page boundaries. Requests
// are issued one at a time, and each one is retired when the transfer level echoes its
// instruction label.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   io_cmd_*                   command handshake (valid/ready, op, addr, len), done/err pulses
//   io_busy                    high whenever the generator is not idle
//   io_tran_inst_label         label echoed by the transfer level when a request completes
//   io_buf_req_*               request bundle to the transfer level (valid/ready handshake)
//
// Optional feature: define QSPI_CMD_TIMEOUT_EN to abort a request whose label echo never
// arrives. The abort happens after 16'hFFFF cycles spent waiting and raises an err pulse.

module qspi_cmd_gen #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned PAGE_WORDS   = 64,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [1:0]  io_cmd_op,
  input  logic [21:0] io_cmd_addr,
  input  logic [8:0]  io_cmd_len,
  output logic        io_cmd_done,
  output logic        io_cmd_err,
  output logic        io_busy,
  input  logic        io_tran_inst_label,
  output logic        io_buf_req_valid,
  input  logic        io_buf_req_ready,
  output logic [7:0]  io_buf_req_inst,
  output logic        io_buf_req_inst_label,
  output logic        io_buf_req_wr_en,
  output logic        io_buf_req_rd_en,
  output logic        io_buf_req_erase_en,
  output logic        io_buf_req_addr_en,
  output logic        io_buf_req_dummy_en,
  output logic [23:0] io_buf_req_addr,
  output logic [7:0]  io_buf_req_data_size,
  output logic [7:0]  io_buf_req_data_burstlen,
  output logic [7:0]  io_buf_req_dummy_size,
  output logic [7:0]  io_buf_req_dummy_burstlen,
  output logic        io_buf_req_addr_mode_en,
  output logic        io_buf_req_addr_spi_mode,
  output logic        io_buf_req_addr_dpi_mode,
  output logic        io_buf_req_data_mode_en,
  output logic        io_buf_req_data_spi_mode,
  output logic        io_buf_req_data_dpi_mode
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpQuad  = 2'b01;
  localparam logic [1:0] OpProg  = 2'b10;
  localparam logic [1:0] OpErase = 2'b11;

  localparam logic [8:0] MaxBurstW  = 9'(MAX_BURST);
  localparam logic [8:0] PageWordsW = 9'(PAGE_WORDS);
  localparam logic [8:0] PageMaskW  = 9'(PAGE_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Per-request fields. They are loaded in CALC and held until the next CALC, so they
  // stay frozen while valid is waiting for ready.
  typedef struct packed {
    logic [7:0] inst;
    logic       wr_en;
    logic       rd_en;
    logic       erase_en;
    logic       addr_en;
    logic       dummy_en;
    logic       addr_mode_en;
    logic       data_mode_en;
    logic [7:0] data_size;
    logic [7:0] dummy_size;
    logic [7:0] dummy_burstlen;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [1:0]  op_q, op_d;
  logic [21:0] waddr_q, waddr_d;
  logic [8:0]  rem_q, rem_d;
  logic [8:0]  chunk_q, chunk_d;
  logic        label_q, label_d;
  logic        err_q, err_d;

  logic [8:0]  burst_lim;
  logic [8:0]  page_room;
  logic [8:0]  chunk_calc;
  logic        label_match;

`ifdef QSPI_CMD_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_err;
`endif

  assign label_match = (io_tran_inst_label == label_q);

  // Chunk size for the next request.
  always_comb begin
    burst_lim  = (rem_q > MaxBurstW) ? MaxBurstW : rem_q;
    // Words left before the next page boundary; PAGE_WORDS is a power of two.
    page_room  = PageWordsW - ({1'b0, waddr_q[7:0]} & PageMaskW);
    chunk_calc = burst_lim;
    if (op_q == OpProg && page_room < burst_lim) begin
      chunk_calc = page_room;
    end
    if (op_q == OpErase) begin
      chunk_calc = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    op_d    = op_q;
    waddr_d = waddr_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    label_d = label_q;
    err_d   = 1'b0;
`ifdef QSPI_CMD_TIMEOUT_EN
    tmo_d   = tmo_q;
    tmo_err = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (io_cmd_valid) begin
          if (io_cmd_op != OpErase && io_cmd_len == 9'd0) begin
            err_d = 1'b1;
          end else begin
            op_d    = io_cmd_op;
            waddr_d = io_cmd_addr;
            rem_d   = io_cmd_len;
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        chunk_d              = chunk_calc;
        label_d              = ~label_q;
        req_d                = '0;
        req_d.addr_en        = 1'b1;
        req_d.data_size      = 8'd32;
        req_d.dummy_size     = 8'(DUMMY_CYCLES);
        req_d.dummy_burstlen = 8'd1;
        unique case (op_q)
          OpRead: begin
            req_d.inst  = 8'h03;
            req_d.rd_en = 1'b1;
          end
          OpQuad: begin
            // Address stays single, data goes quad (mode_en=1, spi=dpi=0).
            req_d.inst         = 8'h6B;
            req_d.rd_en        = 1'b1;
            req_d.dummy_en     = 1'b1;
            req_d.data_mode_en = 1'b1;
          end
          OpProg: begin
            req_d.inst  = 8'h02;
            req_d.wr_en = 1'b1;
          end
          OpErase: begin
            req_d.inst     = 8'h20;
            req_d.erase_en = 1'b1;
          end
          default: ;
        endcase
        state_d = StIssue;
      end

      StIssue: begin
`ifdef QSPI_CMD_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (io_buf_req_ready) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (label_match) begin
          rem_d   = rem_q - chunk_q;
          waddr_d = waddr_q + {13'd0, chunk_q};
          if (op_q == OpErase || rem_q == chunk_q) begin
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
`ifdef QSPI_CMD_TIMEOUT_EN
        end else if (tmo_q == 16'hFFFF) begin
          tmo_err = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
`endif
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      op_q    <= '0;
      waddr_q <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      label_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef QSPI_CMD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
      chunk_q <= chunk_d;
      label_q <= label_d;
      err_q   <= err_d;
`ifdef QSPI_CMD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign io_cmd_ready = (state_q == StIdle);
  assign io_busy      = (state_q != StIdle);
  assign io_cmd_done  = (state_q == StDone);
`ifdef QSPI_CMD_TIMEOUT_EN
  assign io_cmd_err   = err_q | tmo_err;
`else
  assign io_cmd_err   = err_q;
`endif

  assign io_buf_req_valid          = (state_q == StIssue);
  assign io_buf_req_inst           = req_q.inst;
  assign io_buf_req_inst_label     = label_q;
  assign io_buf_req_wr_en          = req_q.wr_en;
  assign io_buf_req_rd_en          = req_q.rd_en;
  assign io_buf_req_erase_en       = req_q.erase_en;
  assign io_buf_req_addr_en        = req_q.addr_en;
  assign io_buf_req_dummy_en       = req_q.dummy_en;
  assign io_buf_req_addr           = {waddr_q, 2'b00};
  assign io_buf_req_data_size      = req_q.data_size;
  assign io_buf_req_data_burstlen  = chunk_q[7:0];
  assign io_buf_req_dummy_size     = req_q.dummy_size;
  assign io_buf_req_dummy_burstlen = req_q.dummy_burstlen;
  assign io_buf_req_addr_mode_en   = req_q.addr_mode_en;
  assign io_buf_req_data_mode_en   = req_q.data_mode_en;
  // Single and quad are the only modes used, so the spi/dpi selects stay low.
  assign io_buf_req_addr_spi_mode  = 1'b0;
  assign io_buf_req_addr_dpi_mode  = 1'b0;
  assign io_buf_req_data_spi_mode  = 1'b0;
  assign io_buf_req_data_dpi_mode  = 1'b0;

endmodule

// File: tb/tb_qspi_cmd_gen.sv
// Self-checking bench for qspi_cmd_gen. The bench plays the transfer level: it accepts
// requests with random ready stalls and echoes labels after random delays. A behavioural
// splitting model supplies the expected request list for random commands.

module tb_qspi_cmd_gen;

  localparam int unsigned MaxBurst    = 16;
  localparam int unsigned PageWords   = 64;
  localparam int unsigned DummyCycles = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_cmd_valid, io_cmd_ready, io_cmd_done, io_cmd_err, io_busy;
  logic [1:0]  io_cmd_op;
  logic [21:0] io_cmd_addr;
  logic [8:0]  io_cmd_len;
  logic        io_tran_inst_label;
  logic        io_buf_req_valid, io_buf_req_ready;
  logic [7:0]  io_buf_req_inst;
  logic        io_buf_req_inst_label;
  logic        io_buf_req_wr_en, io_buf_req_rd_en, io_buf_req_erase_en;
  logic        io_buf_req_addr_en, io_buf_req_dummy_en;
  logic [23:0] io_buf_req_addr;
  logic [7:0]  io_buf_req_data_size, io_buf_req_data_burstlen;
  logic [7:0]  io_buf_req_dummy_size, io_buf_req_dummy_burstlen;
  logic        io_buf_req_addr_mode_en, io_buf_req_addr_spi_mode, io_buf_req_addr_dpi_mode;
  logic        io_buf_req_data_mode_en, io_buf_req_data_spi_mode, io_buf_req_data_dpi_mode;

  always #5 clock = ~clock;

  qspi_cmd_gen #(
    .MAX_BURST   (MaxBurst),
    .PAGE_WORDS  (PageWords),
    .DUMMY_CYCLES(DummyCycles)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_cmd_valid             (io_cmd_valid),
    .io_cmd_ready             (io_cmd_ready),
    .io_cmd_op                (io_cmd_op),
    .io_cmd_addr              (io_cmd_addr),
    .io_cmd_len               (io_cmd_len),
    .io_cmd_done              (io_cmd_done),
    .io_cmd_err               (io_cmd_err),
    .io_busy                  (io_busy),
    .io_tran_inst_label       (io_tran_inst_label),
    .io_buf_req_valid         (io_buf_req_valid),
    .io_buf_req_ready         (io_buf_req_ready),
    .io_buf_req_inst          (io_buf_req_inst),
    .io_buf_req_inst_label    (io_buf_req_inst_label),
    .io_buf_req_wr_en         (io_buf_req_wr_en),
    .io_buf_req_rd_en         (io_buf_req_rd_en),
    .io_buf_req_erase_en      (io_buf_req_erase_en),
    .io_buf_req_addr_en       (io_buf_req_addr_en),
    .io_buf_req_dummy_en      (io_buf_req_dummy_en),
    .io_buf_req_addr          (io_buf_req_addr),
    .io_buf_req_data_size     (io_buf_req_data_size),
    .io_buf_req_data_burstlen (io_buf_req_data_burstlen),
    .io_buf_req_dummy_size    (io_buf_req_dummy_size),
    .io_buf_req_dummy_burstlen(io_buf_req_dummy_burstlen),
    .io_buf_req_addr_mode_en  (io_buf_req_addr_mode_en),
    .io_buf_req_addr_spi_mode (io_buf_req_addr_spi_mode),
    .io_buf_req_addr_dpi_mode (io_buf_req_addr_dpi_mode),
    .io_buf_req_data_mode_en  (io_buf_req_data_mode_en),
    .io_buf_req_data_spi_mode (io_buf_req_data_spi_mode),
    .io_buf_req_data_dpi_mode (io_buf_req_data_dpi_mode)
  );

  typedef struct packed {
    logic [7:0]  inst;
    logic        label, wr, rd, er, aen, den;
    logic [23:0] addr;
    logic [7:0]  dsize, bl, dysize, dybl;
    logic        amen, aspi, adpi, dmen, dspi, ddpi;
  } req_t;

  typedef struct {
    int baddr;
    int bl;
  } exp_t;

  req_t obs_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done, n_err, unstable;
  bit   cmd_finished;
  logic exp_label;

  function automatic req_t cur_req();
    req_t r;
    r.inst = io_buf_req_inst;        r.label = io_buf_req_inst_label;
    r.wr = io_buf_req_wr_en;         r.rd = io_buf_req_rd_en;
    r.er = io_buf_req_erase_en;      r.aen = io_buf_req_addr_en;
    r.den = io_buf_req_dummy_en;     r.addr = io_buf_req_addr;
    r.dsize = io_buf_req_data_size;  r.bl = io_buf_req_data_burstlen;
    r.dysize = io_buf_req_dummy_size; r.dybl = io_buf_req_dummy_burstlen;
    r.amen = io_buf_req_addr_mode_en; r.aspi = io_buf_req_addr_spi_mode;
    r.adpi = io_buf_req_addr_dpi_mode; r.dmen = io_buf_req_data_mode_en;
    r.dspi = io_buf_req_data_spi_mode; r.ddpi = io_buf_req_data_dpi_mode;
    return r;
  endfunction

  // Reference split: walk the word range, cut at MAX_BURST and (program) page ends.
  function automatic void model_split(input int op, input int addr, input int len);
    int wa, rem, c, room;
    exp_q.delete();
    wa = addr;
    rem = len;
    if (op == 3) begin
      exp_q.push_back('{wa * 4, 0});
      return;
    end
    while (rem > 0) begin
      c = (rem < int'(MaxBurst)) ? rem : int'(MaxBurst);
      if (op == 2) begin
        room = int'(PageWords) - (wa % int'(PageWords));
        if (room < c) c = room;
      end
      exp_q.push_back('{wa * 4, c});
      rem -= c;
      wa = (wa + c) % (1 << 22);
    end
  endfunction

  function automatic logic [7:0] exp_inst(input int op);
    case (op)
      0: return 8'h03;
      1: return 8'h6B;
      2: return 8'h02;
      default: return 8'h20;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    io_cmd_valid = 1'b0; io_cmd_op = '0; io_cmd_addr = '0; io_cmd_len = '0;
    io_buf_req_ready = 1'b0; io_tran_inst_label = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_label = 1'b0;
  endtask

  // Drive one command and act as the transfer level until done/err or a cycle budget.
  task automatic run_cmd(input logic [1:0] op, input logic [21:0] addr, input logic [8:0] len,
                         input int ready_pct);
    int   pend;
    logic pend_lbl;
    bit   held, fin;
    req_t snap;
    pend = 0; pend_lbl = 1'b0; held = 0; fin = 0; snap = '0;
    obs_q.delete(); n_done = 0; n_err = 0; unstable = 0;
    @(negedge clock);
    io_cmd_valid = 1'b1; io_cmd_op = op; io_cmd_addr = addr; io_cmd_len = len;
    @(negedge clock);
    io_cmd_valid = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (io_cmd_done) n_done++;
      if (io_cmd_err) n_err++;
      fin = io_cmd_done || io_cmd_err;
      if (pend > 0) begin
        pend--;
        if (pend == 0) io_tran_inst_label = pend_lbl;
      end
      io_buf_req_ready = 1'b0;
      if (io_buf_req_valid) begin
        if (held && cur_req() != snap) unstable++;
        snap = cur_req();
        held = 1;
        if (int'($urandom_range(99)) < ready_pct) begin
          io_buf_req_ready = 1'b1;
          obs_q.push_back(snap);
          held = 0;
          pend = int'($urandom_range(4, 1));
          pend_lbl = snap.label;
        end
      end
      // Junk commands while busy must be ignored.
      if (io_busy && !io_cmd_done) begin
        io_cmd_valid = 1'($urandom_range(1));
        io_cmd_op = 2'($urandom); io_cmd_addr = 22'($urandom); io_cmd_len = 9'($urandom);
      end else begin
        io_cmd_valid = 1'b0;
      end
      if (!fin) @(negedge clock);
    end
    io_cmd_valid = 1'b0;
    io_buf_req_ready = 1'b0;
    cmd_finished = fin;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (io_cmd_ready !== 1'b1) begin n_errors++;
      $display("FAIL reset_ready: got %b want 1", io_cmd_ready); end
    n_checks++; if ({io_busy, io_cmd_done, io_cmd_err} !== 3'b000) begin n_errors++;
      $display("FAIL reset_status: got %b want 000", {io_busy, io_cmd_done, io_cmd_err}); end
    n_checks++; if (io_buf_req_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_valid: got %b want 0", io_buf_req_valid); end
    n_checks++; if (cur_req() !== '0) begin n_errors++;
      $display("FAIL reset_req_fields: got %h want 0", cur_req()); end
  endtask

  task automatic test_read_split();
    int ea[3] = '{32'h40, 32'h80, 32'hC0};
    int eb[3] = '{16, 16, 8};
    do_reset();
    run_cmd(2'b00, 22'h000010, 9'd40, 60);
    n_checks++; if (!cmd_finished || obs_q.size() != 3) begin n_errors++;
      $display("FAIL read_count: got %0d reqs fin=%0b want 3", obs_q.size(), cmd_finished); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      exp_label = ~exp_label;
      n_checks++;
      if (obs_q[i].addr !== 24'(ea[i]) || obs_q[i].bl !== 8'(eb[i]) || obs_q[i].inst !== 8'h03
          || obs_q[i].label !== exp_label || {obs_q[i].rd, obs_q[i].wr} !== 2'b10) begin
        n_errors++;
        $display("FAIL read_req%0d: got addr=%h bl=%0d inst=%h lbl=%b want addr=%h bl=%0d inst=03 lbl=%b",
                 i, obs_q[i].addr, obs_q[i].bl, obs_q[i].inst, obs_q[i].label, ea[i], eb[i],
                 exp_label);
      end
    end
    n_checks++; if (n_done != 1 || n_err != 0) begin n_errors++;
      $display("FAIL read_done: got done=%0d err=%0d want 1/0", n_done, n_err); end
  endtask

  task automatic test_program_page();
    run_cmd(2'b10, 22'h00003C, 9'd10, 80);
    n_checks++; if (obs_q.size() != 2) begin n_errors++;
      $display("FAIL prog_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      exp_label = ~exp_label;
      n_checks++; if ({obs_q[0].addr, obs_q[0].bl, obs_q[0].wr, obs_q[0].label}
                      !== {24'hF0, 8'd4, 1'b1, exp_label}) begin n_errors++;
        $display("FAIL prog_req0: got addr=%h bl=%0d wr=%b want F0/4/1", obs_q[0].addr,
                 obs_q[0].bl, obs_q[0].wr); end
      exp_label = ~exp_label;
      n_checks++; if ({obs_q[1].addr, obs_q[1].bl, obs_q[1].wr, obs_q[1].label}
                      !== {24'h100, 8'd6, 1'b1, exp_label}) begin n_errors++;
        $display("FAIL prog_req1: got addr=%h bl=%0d wr=%b want 100/6/1", obs_q[1].addr,
                 obs_q[1].bl, obs_q[1].wr); end
    end
    n_checks++; if (n_done != 1) begin n_errors++;
      $display("FAIL prog_done: got %0d want 1", n_done); end
  endtask

  task automatic test_quad();
    run_cmd(2'b01, 22'h000123, 9'd4, 100);
    n_checks++; if (obs_q.size() != 1) begin n_errors++;
      $display("FAIL quad_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      exp_label = ~exp_label;
      n_checks++; if ({obs_q[0].inst, obs_q[0].den, obs_q[0].dysize, obs_q[0].dybl}
                      !== {8'h6B, 1'b1, 8'd8, 8'd1}) begin n_errors++;
        $display("FAIL quad_inst_dummy: got inst=%h den=%b dsz=%0d dbl=%0d want 6B/1/8/1",
                 obs_q[0].inst, obs_q[0].den, obs_q[0].dysize, obs_q[0].dybl); end
      n_checks++; if ({obs_q[0].amen, obs_q[0].dmen, obs_q[0].dspi, obs_q[0].ddpi}
                      !== 4'b0100) begin n_errors++;
        $display("FAIL quad_modes: got %b want 0100",
                 {obs_q[0].amen, obs_q[0].dmen, obs_q[0].dspi, obs_q[0].ddpi}); end
      n_checks++; if ({obs_q[0].addr, obs_q[0].bl, obs_q[0].dsize, obs_q[0].label}
                      !== {24'h00048C, 8'd4, 8'd32, exp_label}) begin n_errors++;
        $display("FAIL quad_addr: got addr=%h bl=%0d dsize=%0d want 48C/4/32", obs_q[0].addr,
                 obs_q[0].bl, obs_q[0].dsize); end
    end
  endtask

  task automatic test_erase_and_len0();
    run_cmd(2'b11, 22'h000400, 9'd0, 100);
    n_checks++; if (obs_q.size() != 1 || n_done != 1) begin n_errors++;
      $display("FAIL erase_count: got reqs=%0d done=%0d want 1/1", obs_q.size(), n_done); end
    if (obs_q.size() == 1) begin
      exp_label = ~exp_label;
      n_checks++; if ({obs_q[0].addr, obs_q[0].bl, obs_q[0].er, obs_q[0].inst, obs_q[0].aen,
                       obs_q[0].label} !== {24'h001000, 8'd0, 1'b1, 8'h20, 1'b1, exp_label})
      begin n_errors++;
        $display("FAIL erase_req: got addr=%h bl=%0d er=%b inst=%h want 1000/0/1/20",
                 obs_q[0].addr, obs_q[0].bl, obs_q[0].er, obs_q[0].inst); end
    end
    run_cmd(2'b00, 22'h000077, 9'd0, 100);
    n_checks++; if (n_err != 1 || n_done != 0 || obs_q.size() != 0) begin n_errors++;
      $display("FAIL len0_err: got err=%0d done=%0d reqs=%0d want 1/0/0", n_err, n_done,
               obs_q.size()); end
  endtask

  task automatic test_hold_reset();
    req_t snap;
    bit   seen;
    int   diffs;
    @(negedge clock);
    io_cmd_valid = 1'b1; io_cmd_op = 2'b00; io_cmd_addr = 22'h5; io_cmd_len = 9'd20;
    @(negedge clock);
    io_cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (io_buf_req_valid) seen = 1;
      else @(negedge clock);
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL hold_valid: got 0 want 1"); end
    snap = cur_req();
    diffs = 0;
    repeat (5) begin
      @(negedge clock);
      if (cur_req() != snap || io_buf_req_valid !== 1'b1) diffs++;
    end
    n_checks++; if (diffs != 0) begin n_errors++;
      $display("FAIL hold_stable: got %0d changed cycles want 0", diffs); end
    io_buf_req_ready = 1'b1;
    @(negedge clock);
    io_buf_req_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if ({io_buf_req_valid, io_busy} !== 2'b01) begin n_errors++;
      $display("FAIL hold_wait: got valid,busy=%b want 01", {io_buf_req_valid, io_busy}); end
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if ({io_cmd_ready, io_busy, io_buf_req_valid, io_cmd_done, io_cmd_err} !== 5'b10000)
    begin n_errors++;
      $display("FAIL midreset_status: got %b want 10000",
               {io_cmd_ready, io_busy, io_buf_req_valid, io_cmd_done, io_cmd_err}); end
    n_checks++; if (cur_req() !== '0) begin n_errors++;
      $display("FAIL midreset_fields: got %h want 0", cur_req()); end
    reset = 1'b0;
    io_tran_inst_label = 1'b0;
    exp_label = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [21:0] addr;
    logic [8:0]  len;
    logic [3:0]  exp_flags;
    for (int k = 0; k < 8; k++) begin
      op   = 2'($urandom_range(3));
      addr = (k % 3 == 0) ? 22'h3FFFFF - 22'($urandom_range(40)) : 22'($urandom);
      len  = 9'($urandom_range(256, 1));
      run_cmd(op, addr, len, 70);
      model_split(int'(op), int'(addr), int'(len));
      exp_flags = {op == 2'b10, op[1] == 1'b0, op == 2'b11, op == 2'b01};
      n_checks++; if (obs_q.size() != exp_q.size() || n_done != 1 || n_err != 0) begin
        n_errors++;
        $display("FAIL rnd%0d_count: op=%0d addr=%h len=%0d got reqs=%0d done=%0d want %0d/1",
                 k, op, addr, len, obs_q.size(), n_done, exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        exp_label = ~exp_label;
        n_checks++;
        if (obs_q[i].addr !== 24'(exp_q[i].baddr) || obs_q[i].bl !== 8'(exp_q[i].bl)
            || obs_q[i].inst !== exp_inst(int'(op)) || obs_q[i].label !== exp_label
            || {obs_q[i].wr, obs_q[i].rd, obs_q[i].er, obs_q[i].den} !== exp_flags) begin
          n_errors++;
          $display("FAIL rnd%0d_req%0d: got addr=%h bl=%0d inst=%h lbl=%b want addr=%h bl=%0d lbl=%b",
                   k, i, obs_q[i].addr, obs_q[i].bl, obs_q[i].inst, obs_q[i].label,
                   24'(exp_q[i].baddr), exp_q[i].bl, exp_label);
        end
      end
      n_checks++; if (unstable != 0) begin n_errors++;
        $display("FAIL rnd%0d_stable: got %0d changes want 0", k, unstable); end
    end
  endtask

`ifdef QSPI_CMD_TIMEOUT_EN
  task automatic test_timeout();
    logic lbl;
    bit   got;
    int   waited;
    do_reset();
    @(negedge clock);
    io_cmd_valid = 1'b1; io_cmd_op = 2'b00; io_cmd_addr = '0; io_cmd_len = 9'd1;
    @(negedge clock);
    io_cmd_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (io_buf_req_valid) got = 1;
      else @(negedge clock);
    end
    lbl = io_buf_req_inst_label;
    io_buf_req_ready = 1'b1;
    @(negedge clock);
    io_buf_req_ready = 1'b0;
    got = 0; waited = 0;
    for (int c = 1; c <= 70000 && !got; c++) begin
      if (io_cmd_err || io_cmd_done) begin got = 1; waited = c; end
      else @(negedge clock);
    end
    n_checks++; if (!got || io_cmd_err !== 1'b1 || io_cmd_done !== 1'b0) begin n_errors++;
      $display("FAIL tmo_err: got seen=%0b err=%b done=%b want 1/1/0", got, io_cmd_err,
               io_cmd_done); end
    n_checks++; if (waited < 65534 || waited > 65537) begin n_errors++;
      $display("FAIL tmo_cycles: got %0d want about 65535", waited); end
    @(negedge clock);
    n_checks++; if ({io_busy, io_buf_req_inst_label} !== {1'b0, lbl}) begin n_errors++;
      $display("FAIL tmo_after: got busy,lbl=%b want 0%b", {io_busy, io_buf_req_inst_label},
               lbl); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_read_split();
    test_program_page();
    test_quad();
    test_erase_and_len0();
    test_hold_reset();
    test_random();
`ifdef QSPI_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
